// File: rtl/countdown_tens_sec.sv
// countdown_tens_sec
// Tens-of-seconds digit of the countdown timer. A mod-(MAX_VAL+1) down-counter
// fed by one-cycle borrow ticks from the units stage. On a tick at zero it either
// wraps to MAX_VAL and sends a registered borrow to the minutes stage, or, when
// it is the terminal digit (last_in_i), it stops in EXPIRED with done_o high.
// The digit drives a 7-segment display (active-high a..g) directly.
//
// Optional feature macro: COUNTDOWN_BLINK_EN
//   When defined, the segments blink while EXPIRED. Each half-period lasts
//   BLINK_CYCLES clocks, and the first half-period is blank.
//   When undefined, EXPIRED shows a steady "0" and no blink counter exists.
//
// Ports
//   clk_i          system clock, all state on the rising edge
//   rst_n_i        asynchronous active-low reset
//   tick_i         one-cycle borrow pulse from the units stage
//   last_in_i      all higher digits are zero (this stage is terminal)
//   start_i        one-cycle pulse, begin/resume counting
//   stop_i         one-cycle pulse, pause
//   load_i         one-cycle pulse, load load_val_i (saturated to MAX_VAL)
//   load_val_i     preset value
//   digit_o        current value 0..MAX_VAL
//   borrow_out_o   one-cycle registered borrow to the next stage
//   zero_o         digit_o == 0
//   done_o         high while EXPIRED
//   ads_o..gds_o   segments a..g, active-high
module countdown_tens_sec #(
  parameter int MAX_VAL      = 5,
  parameter int BLINK_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       tick_i,
  input  logic       last_in_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       load_i,
  input  logic [2:0] load_val_i,
  output logic [2:0] digit_o,
  output logic       borrow_out_o,
  output logic       zero_o,
  output logic       done_o,
  output logic       ads_o,
  output logic       bds_o,
  output logic       cds_o,
  output logic       dds_o,
  output logic       eds_o,
  output logic       fds_o,
  output logic       gds_o
);

  if (MAX_VAL < 1 || MAX_VAL > 7 || BLINK_CYCLES < 1) begin : g_param_check
    $error("countdown_tens_sec: MAX_VAL must be 1..7 and BLINK_CYCLES >= 1");
  end

  localparam logic [2:0] MaxD = 3'(MAX_VAL);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_EXPIRED = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] digit_q, digit_d;
  logic       borrow_q, borrow_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_STOPPED;
      digit_q  <= 3'd0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      digit_q  <= digit_d;
      borrow_q <= borrow_d;
    end
  end

  // Priority: LOAD > STOP > START > TICK. The borrow defaults low so it can
  // never last more than the single cycle after a wrap.
  always_comb begin
    state_d  = state_q;
    digit_d  = digit_q;
    borrow_d = 1'b0;
    if (load_i) begin
      digit_d = (load_val_i > MaxD) ? MaxD : load_val_i;
      state_d = ST_STOPPED;
    end else begin
      unique case (state_q)
        ST_STOPPED: begin
          if (!stop_i && start_i) state_d = ST_RUNNING;
        end
        ST_RUNNING: begin
          if (stop_i) begin
            state_d = ST_STOPPED;
          end else if (tick_i) begin
            if (digit_q != 3'd0) begin
              digit_d = digit_q - 3'd1;
            end else if (!last_in_i) begin
              digit_d  = MaxD;
              borrow_d = 1'b1;
            end else begin
              state_d = ST_EXPIRED;
            end
          end
        end
        ST_EXPIRED: begin
          // Only LOAD or reset leaves this state.
        end
        default: state_d = ST_STOPPED;
      endcase
    end
  end

  logic seg_en;

`ifdef COUNTDOWN_BLINK_EN
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  // The phase restarts (blank, count 0) on every entry into EXPIRED because
  // it is held clear whenever the next state is anything else.
  always_comb begin
    blink_cnt_d = '0;
    blink_on_d  = 1'b0;
    if (state_q == ST_EXPIRED && state_d == ST_EXPIRED) begin
      if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_on_d  = blink_on_q;
      end
    end
  end

  assign seg_en = (state_q != ST_EXPIRED) || blink_on_q;
`else
  assign seg_en = 1'b1;
`endif

  // Segment pattern ordered {a,b,c,d,e,f,g}.
  logic [6:0] seg_raw;
  always_comb begin
    seg_raw = 7'b0000000;
    unique case (digit_q)
      3'd0: seg_raw = 7'b1111110;
      3'd1: seg_raw = 7'b0110000;
      3'd2: seg_raw = 7'b1101101;
      3'd3: seg_raw = 7'b1111001;
      3'd4: seg_raw = 7'b0110011;
      3'd5: seg_raw = 7'b1011011;
      3'd6: seg_raw = 7'b1011111;
      3'd7: seg_raw = 7'b1110000;
      default: seg_raw = 7'b0000000;
    endcase
  end

  logic [6:0] seg;
  assign seg = seg_en ? seg_raw : 7'b0000000;

  assign {ads_o, bds_o, cds_o, dds_o, eds_o, fds_o, gds_o} = seg;

  assign digit_o      = digit_q;
  assign borrow_out_o = borrow_q;
  assign zero_o       = (digit_q == 3'd0);
  assign done_o       = (state_q == ST_EXPIRED);

endmodule

// File: tb/tb_countdown_tens_sec.sv
module tb_countdown_tens_sec;

  localparam int MAXV  = 5;
  localparam int BLINK = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, last_in = 1'b0, start = 1'b0, stop = 1'b0, load = 1'b0;
  logic [2:0] load_val = 3'd0;
  logic [2:0] digit;
  logic       borrow, zero, done;
  logic       a_s, b_s, c_s, d_s, e_s, f_s, g_s;
  logic [6:0] segs;

  assign segs = {a_s, b_s, c_s, d_s, e_s, f_s, g_s};

  always #5 clk = ~clk;

  countdown_tens_sec #(.MAX_VAL(MAXV), .BLINK_CYCLES(BLINK)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .tick_i(tick), .last_in_i(last_in),
    .start_i(start), .stop_i(stop), .load_i(load), .load_val_i(load_val),
    .digit_o(digit), .borrow_out_o(borrow), .zero_o(zero), .done_o(done),
    .ads_o(a_s), .bds_o(b_s), .cds_o(c_s), .dds_o(d_s), .eds_o(e_s),
    .fds_o(f_s), .gds_o(g_s)
  );

  int checks = 0;
  int errors = 0;
  int txn = 0;

  // Reference model: 0 = stopped, 1 = running, 2 = expired.
  int m_digit, m_state, m_exp_age;
  bit m_borrow;

  // Digit glyphs from the display map, {a..g}.
  logic [6:0] glyph [8];
  initial begin
    glyph[0] = 7'b1111110; glyph[1] = 7'b0110000;
    glyph[2] = 7'b1101101; glyph[3] = 7'b1111001;
    glyph[4] = 7'b0110011; glyph[5] = 7'b1011011;
    glyph[6] = 7'b1011111; glyph[7] = 7'b1110000;
  end

  task automatic model_reset();
    m_digit = 0; m_state = 0; m_borrow = 0; m_exp_age = 0;
  endtask

  function automatic logic [6:0] exp_segs();
`ifdef COUNTDOWN_BLINK_EN
    if (m_state == 2 && ((m_exp_age / BLINK) % 2) == 0) return 7'b0000000;
`endif
    return glyph[m_digit];
  endfunction

  // One clock of stimulus; the model is advanced from the specified rules.
  task automatic step(input bit tk, input bit lst, input bit st, input bit sp,
                      input bit ld, input int lv);
    int prev_state;
    @(negedge clk);
    tick = tk; last_in = lst; start = st; stop = sp; load = ld; load_val = 3'(lv);
    @(posedge clk);
    prev_state = m_state;
    m_borrow = 0;
    if (ld) begin
      m_digit = (lv > MAXV) ? MAXV : lv;
      m_state = 0;
    end else if (m_state == 1) begin
      if (sp) m_state = 0;
      else if (tk) begin
        if (m_digit > 0) m_digit--;
        else if (!lst) begin m_digit = MAXV; m_borrow = 1; end
        else m_state = 2;
      end
    end else if (m_state == 0 && st && !sp) begin
      m_state = 1;
    end
    if (m_state == 2) m_exp_age = (prev_state == 2) ? m_exp_age + 1 : 0;
    #1;
    txn++;
    $display("txn %0d tick=%0b last=%0b start=%0b stop=%0b load=%0b lv=%0d -> digit=%0d borrow=%0b done=%0b segs=%b",
             txn, tk, lst, st, sp, ld, lv, digit, borrow, done, segs);
    tick = 0; start = 0; stop = 0; load = 0;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    #1;
    checks++;
    if (digit !== 3'd0 || borrow !== 1'b0 || done !== 1'b0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs got digit=%0d borrow=%0b done=%0b zero=%0b want 0 0 0 1",
               digit, borrow, done, zero);
    end
    checks++;
    if (segs !== 7'b1111110) begin
      errors++; $display("FAIL reset_segs got %b want 1111110", segs);
    end
  endtask

  task automatic test_basic_count();
    step(0, 0, 0, 0, 1, 3);
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 0);
      checks++;
      if (digit !== 3'(2 - i) || borrow !== 1'b0) begin
        errors++;
        $display("FAIL basic_dec%0d got digit=%0d borrow=%0b want %0d 0", i, digit, borrow, 2 - i);
      end
    end
    checks++;
    if (zero !== 1'b1) begin errors++; $display("FAIL basic_zero got %0b want 1", zero); end
  endtask

  task automatic test_wrap();
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if (digit !== 3'd5 || borrow !== 1'b1 || zero !== 1'b0) begin
      errors++;
      $display("FAIL wrap got digit=%0d borrow=%0b zero=%0b want 5 1 0", digit, borrow, zero);
    end
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (digit !== 3'd5 || borrow !== 1'b0) begin
      errors++; $display("FAIL wrap_after got digit=%0d borrow=%0b want 5 0", digit, borrow);
    end
  endtask

  task automatic test_expire();
    step(0, 1, 0, 0, 1, 0);
    step(0, 1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    checks++;
    if (done !== 1'b1 || digit !== 3'd0 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL expire got done=%0b digit=%0d borrow=%0b want 1 0 0", done, digit, borrow);
    end
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    checks++;
    if (done !== 1'b1 || digit !== 3'd0 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL expire_hold got done=%0b digit=%0d borrow=%0b want 1 0 0", done, digit, borrow);
    end
    step(0, 0, 0, 0, 1, 7);
    checks++;
    if (done !== 1'b0 || digit !== 3'd5) begin
      errors++; $display("FAIL expire_load got done=%0b digit=%0d want 0 5", done, digit);
    end
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if (digit !== 3'd5) begin
      errors++; $display("FAIL expire_stopped got digit=%0d want 5", digit);
    end
  endtask

  task automatic test_priority();
    step(0, 0, 0, 0, 1, 4);
    step(0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    checks++;
    if (digit !== 3'd4) begin errors++; $display("FAIL prio_stop got digit=%0d want 4", digit); end
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if (digit !== 3'd4) begin errors++; $display("FAIL prio_stopped got digit=%0d want 4", digit); end
    step(0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 2);
    checks++;
    if (digit !== 3'd2) begin errors++; $display("FAIL prio_load got digit=%0d want 2", digit); end
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if (digit !== 3'd2) begin errors++; $display("FAIL prio_load_stop got digit=%0d want 2", digit); end
  endtask

  task automatic test_segments();
    step(0, 0, 0, 0, 1, 5);
    checks++;
    if (segs !== 7'b1011011) begin errors++; $display("FAIL seg_5 got %b want 1011011", segs); end
    step(0, 0, 1, 0, 0, 0);
    for (int v = 4; v >= 0; v--) begin
      step(1, 0, 0, 0, 0, 0);
      checks++;
      if (segs !== glyph[v] || digit !== 3'(v)) begin
        errors++; $display("FAIL seg_%0d got %b digit %0d want %b", v, segs, digit, glyph[v]);
      end
    end
    for (int v = 6; v <= 7; v++) begin
      step(0, 0, 0, 0, 1, v);
      checks++;
      if (segs !== glyph[5]) begin
        errors++; $display("FAIL seg_sat%0d got %b want %b", v, segs, glyph[5]);
      end
    end
  endtask

  task automatic test_async_reset();
    step(0, 0, 0, 0, 1, 3);
    step(0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    #1 rst_n = 0;
    #1;
    checks++;
    if (digit !== 3'd0 || segs !== 7'b1111110 || done !== 1'b0 || borrow !== 1'b0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got digit=%0d segs=%b done=%0b borrow=%0b zero=%0b want 0 1111110 0 0 1",
               digit, segs, done, borrow, zero);
    end
    @(negedge clk); rst_n = 1;
    model_reset();
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if (digit !== 3'd0 || done !== 1'b0) begin
      errors++; $display("FAIL post_reset got digit=%0d done=%0b want 0 0", digit, done);
    end
  endtask

  task automatic test_blink();
    step(0, 1, 0, 0, 1, 0);
    step(0, 1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      logic [6:0] want;
`ifdef COUNTDOWN_BLINK_EN
      want = (((i / BLINK) % 2) == 0) ? 7'b0000000 : 7'b1111110;
`else
      want = 7'b1111110;
`endif
      checks++;
      if (segs !== want || done !== 1'b1 || zero !== 1'b1) begin
        errors++;
        $display("FAIL blink_%0d got segs=%b done=%0b zero=%0b want %b 1 1", i, segs, done, zero, want);
      end
      step($urandom_range(0, 1), 1, $urandom_range(0, 1), 0, 0, 0);
    end
    step(0, 0, 0, 0, 1, 2);
    checks++;
    if (segs !== glyph[2] || done !== 1'b0) begin
      errors++; $display("FAIL blink_exit got segs=%b done=%0b want %b 0", segs, done, glyph[2]);
    end
  endtask

  task automatic test_back_to_back();
    bit prev_b;
    step(0, 0, 0, 0, 1, 5);
    step(0, 0, 1, 0, 0, 0);
    prev_b = 0;
    for (int i = 0; i < 15; i++) begin
      step(1, 0, 0, 0, 0, 0);
      checks++;
      if (digit !== 3'(m_digit) || borrow !== m_borrow || (prev_b && borrow)) begin
        errors++;
        $display("FAIL b2b_%0d got digit=%0d borrow=%0b want %0d %0b", i, digit, borrow, m_digit, m_borrow);
      end
      prev_b = borrow;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit tk, lst, st, sp, ld;
      tk  = ($urandom_range(0, 1) == 1);
      lst = ($urandom_range(0, 3) == 0);
      st  = ($urandom_range(0, 5) == 0);
      sp  = ($urandom_range(0, 15) == 0);
      ld  = ($urandom_range(0, 19) == 0);
      step(tk, lst, st, sp, ld, int'($urandom_range(0, 7)));
      checks++;
      if (digit !== 3'(m_digit) || borrow !== m_borrow || done !== (m_state == 2) ||
          zero !== (m_digit == 0) || segs !== exp_segs()) begin
        errors++;
        $display("FAIL rnd_%0d got digit=%0d borrow=%0b done=%0b zero=%0b segs=%b want %0d %0b %0b %0b %b",
                 i, digit, borrow, done, zero, segs, m_digit, m_borrow, m_state == 2,
                 m_digit == 0, exp_segs());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_wrap();
    test_expire();
    test_priority();
    test_segments();
    test_async_reset();
    test_blink();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
